mac_frame_scheduler: RTL

Round-robin scheduler that shares one `mac_frame_generator` between `NUM_REQ` traffic requesters. It picks a requester, drives the generator's `i_start`, `i_eth_type` and `i_interrupt` for exactly the frame's 64-bit beat count, then enforces an inter-packet gap before the next frame. It acknowledges each requester with a one-cycle grant and rejects oversize payloads. It sits between the test-traffic sources and the frame generator in the MII/BASE-R transmit path.

---
 rtl/mac_frame_scheduler.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/mac_frame_scheduler.sv
// mac_frame_scheduler
// Round-robin arbiter that shares one mac_frame_generator between NUM_REQ
// traffic requesters. A winning requester's length and mode are latched and
// o_start is held for the frame's 64-bit beat count. Each frame is followed by
// an inter-packet gap. Every request is closed with a one-cycle grant, and
// oversize payloads are rejected with o_err.
// Optional feature: define MAC_SCHED_STATS_EN to build the saturating
// completed-frame counter on o_frame_cnt. When it is undefined, o_frame_cnt is tied to 0.
module mac_frame_scheduler #(
  parameter int NUM_REQ          = 4,
  parameter int PAYLOAD_MAX_SIZE = 1500,
  parameter int IPG_CYCLES       = 2
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_enable,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ*16-1:0]      i_len,
  input  logic [NUM_REQ*8-1:0]       i_mode,
  output logic                       o_start,
  output logic [15:0]                o_eth_type,
  output logic [7:0]                 o_interrupt,
  output logic [$clog2(NUM_REQ)-1:0] o_active,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic                       o_err,
  output logic                       o_busy,
  output logic [31:0]                o_frame_cnt
);

  localparam int                  PTR_W    = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0]    LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W-1:0]    ONE_IDX  = PTR_W'(1);
  localparam logic [NUM_REQ-1:0]  ONE_HOT0 = NUM_REQ'(1);
  localparam logic [15:0]         MAX_LEN  = 16'(PAYLOAD_MAX_SIZE);
  localparam logic [16:0]         MIN_LEN  = 17'd46;
  localparam bit                  GAP_EN   = (IPG_CYCLES != 0);
  localparam logic [3:0]          GAP_LOAD = (IPG_CYCLES == 0) ? 4'd0 : 4'(IPG_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_IPG  = 2'd2
  } state_t;

  // Beats on the wire: padded payload plus 26 bytes of preamble/SFD, header
  // and CRC, rounded up to whole 8-byte beats (+33 = +26 overhead +7 round-up).
  function automatic logic [16:0] calc_beats(input logic [15:0] len);
    logic [16:0] l_v;
    if ({1'b0, len} < MIN_LEN) begin
      l_v = MIN_LEN;
    end else begin
      l_v = {1'b0, len};
    end
    calc_beats = (l_v + 17'd33) >> 3'd3;
  endfunction

  // Round-robin pointer advance with wrap at NUM_REQ.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == LAST_IDX) begin
      next_ptr = {PTR_W{1'b0}};
    end else begin
      next_ptr = p + ONE_IDX;
    end
  endfunction

  state_t               state_r, state_next_s;
  logic [PTR_W-1:0]     rr_ptr_r, rr_ptr_next_s;
  logic [16:0]          beat_cnt_r, beat_cnt_next_s;
  logic [3:0]           gap_cnt_r, gap_cnt_next_s;
  logic                 start_r, start_next_s;
  logic [15:0]          eth_type_r, eth_type_next_s;
  logic [7:0]           interrupt_r, interrupt_next_s;
  logic [PTR_W-1:0]     active_r, active_next_s;
  logic [NUM_REQ-1:0]   grant_r, grant_next_s;
  logic                 err_r, err_next_s;
  logic                 busy_r;

  logic                 arb_ok_s;
  logic                 win_found_s;
  logic [PTR_W-1:0]     win_idx_s;
  logic [15:0]          win_len_s;
  logic [7:0]           win_mode_s;

  // A grant cycle never arbitrates, so a requester still holding i_req in its
  // grant cycle cannot be served twice for one request.
  assign arb_ok_s   = i_enable & (|i_req) & ~(|grant_r);
  assign win_len_s  = i_len[16*win_idx_s +: 16];
  assign win_mode_s = i_mode[8*win_idx_s +: 8];

  // Winner search: first set request at or after rr_ptr, wrapping upward.
  always_comb begin
    int               idx_v;
    logic [PTR_W-1:0] cand_v;
    win_found_s = 1'b0;
    win_idx_s   = {PTR_W{1'b0}};
    idx_v       = 0;
    cand_v      = {PTR_W{1'b0}};
    // Walk from farthest to nearest so the nearest hit is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_v  = (int'(rr_ptr_r) + k) % NUM_REQ;
      cand_v = PTR_W'(idx_v);
      if (i_req[cand_v]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_v;
      end else begin
      end
    end
  end

  // Next-state and next-output decode for the IDLE/SEND/IPG sequencer.
  always_comb begin
    state_next_s     = state_r;
    rr_ptr_next_s    = rr_ptr_r;
    beat_cnt_next_s  = beat_cnt_r;
    gap_cnt_next_s   = gap_cnt_r;
    start_next_s     = start_r;
    eth_type_next_s  = eth_type_r;
    interrupt_next_s = interrupt_r;
    active_next_s    = active_r;
    grant_next_s     = {NUM_REQ{1'b0}};
    err_next_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (arb_ok_s && win_found_s) begin
          if (win_len_s > MAX_LEN) begin
            // Oversize: close the request with grant+err and move on.
            grant_next_s  = ONE_HOT0 << win_idx_s;
            err_next_s    = 1'b1;
            rr_ptr_next_s = next_ptr(win_idx_s);
          end else begin
            eth_type_next_s  = win_len_s;
            interrupt_next_s = win_mode_s;
            active_next_s    = win_idx_s;
            beat_cnt_next_s  = calc_beats(win_len_s) - 17'd1;
            start_next_s     = 1'b1;
            state_next_s     = ST_SEND;
          end
        end else begin
        end
      end
      ST_SEND: begin
        if (beat_cnt_r == 17'd0) begin
          start_next_s  = 1'b0;
          grant_next_s  = ONE_HOT0 << active_r;
          rr_ptr_next_s = next_ptr(active_r);
          if (GAP_EN) begin
            gap_cnt_next_s = GAP_LOAD;
            state_next_s   = ST_IPG;
          end else begin
            state_next_s   = ST_IDLE;
          end
        end else begin
          beat_cnt_next_s = beat_cnt_r - 17'd1;
        end
      end
      ST_IPG: begin
        if (gap_cnt_r == 4'd0) begin
          state_next_s = ST_IDLE;
        end else begin
          gap_cnt_next_s = gap_cnt_r - 4'd1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        start_next_s = 1'b0;
      end
    endcase
  end

  // State and registered-output update; reset drops any frame in flight.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= {PTR_W{1'b0}};
      beat_cnt_r  <= 17'd0;
      gap_cnt_r   <= 4'd0;
      start_r     <= 1'b0;
      eth_type_r  <= 16'd0;
      interrupt_r <= 8'd0;
      active_r    <= {PTR_W{1'b0}};
      grant_r     <= {NUM_REQ{1'b0}};
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      rr_ptr_r    <= rr_ptr_next_s;
      beat_cnt_r  <= beat_cnt_next_s;
      gap_cnt_r   <= gap_cnt_next_s;
      start_r     <= start_next_s;
      eth_type_r  <= eth_type_next_s;
      interrupt_r <= interrupt_next_s;
      active_r    <= active_next_s;
      grant_r     <= grant_next_s;
      err_r       <= err_next_s;
      busy_r      <= (state_next_s != ST_IDLE);
    end
  end

  assign o_start     = start_r;
  assign o_eth_type  = eth_type_r;
  assign o_interrupt = interrupt_r;
  assign o_active    = active_r;
  assign o_grant     = grant_r;
  assign o_err       = err_r;
  assign o_busy      = busy_r;

`ifdef MAC_SCHED_STATS_EN
  logic [31:0] frame_cnt_r;
  logic        frame_done_s;

  // A frame completes on the edge that leaves the last SEND beat.
  assign frame_done_s = (state_r == ST_SEND) && (beat_cnt_r == 17'd0);

  // Saturating completed-frame counter, cleared only by reset.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt_r <= 32'd0;
    end else if (frame_done_s && (frame_cnt_r != 32'hFFFF_FFFF)) begin
      frame_cnt_r <= frame_cnt_r + 32'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign o_frame_cnt = frame_cnt_r;
`else
  assign o_frame_cnt = 32'd0;
`endif

endmodule
